// File: rtl/sa_tile_ctrl.sv
// Tile sequencer for the 8x8 systolic PE array: streams operands into the array loaders,
// starts and watchdogs the compute, then drains the C tile into a result FIFO.
//
// state      | meaning
// IDLE       | waiting for a tile command (cmd_ready=1)
// LDSTART    | one-cycle loader start pulse(s)
// LD_A       | forwarding A words from the operand stream
// LD_B       | forwarding B words from the operand stream
// WAIT_LD    | waiting for the array to finish loading
// WAIT_DONE  | array computing, watchdog running
// DRAIN_REQ  | waiting for an empty FIFO before requesting the drain
// DRAIN      | pushing C words into the FIFO until last
module sa_tile_ctrl #(
    parameter int SIDE     = 8,
    parameter int K_CYCLES = 8,
    parameter int ACC_BITS = 32,
    parameter int TIMEOUT  = 1023
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_reuse_b,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [31:0]         s_data,
    output logic                arr_a_ld_start,
    output logic                arr_a_ld_valid,
    output logic [31:0]         arr_a_ld_data,
    output logic                arr_b_ld_start,
    output logic                arr_b_ld_valid,
    output logic [31:0]         arr_b_ld_data,
    input  logic                arr_ld_done,
    output logic                arr_start,
    input  logic                arr_done,
    output logic                arr_c_drain_req,
    input  logic                arr_c_valid,
    input  logic [ACC_BITS-1:0] arr_c_data,
    input  logic                arr_c_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [ACC_BITS-1:0] m_data,
    output logic                m_last,
    output logic                busy,
    output logic                err,
    output logic [15:0]         tile_cnt
);

    localparam int LD_WORDS = SIDE * K_CYCLES / 4;
    localparam int BW       = (LD_WORDS > 1) ? $clog2(LD_WORDS) : 1;
    localparam int DEPTH    = SIDE * SIDE;
    localparam int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW       = PW + 1;
    localparam int WW       = $clog2(TIMEOUT + 1);

    localparam logic [BW-1:0] LD_LAST  = BW'(LD_WORDS - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LDSTART, S_LD_A, S_LD_B, S_WAIT_LD, S_WAIT_DONE, S_DRAIN_REQ, S_DRAIN
    } state_t;

    state_t            state, state_nxt;
    logic [BW-1:0]     beat_cnt, beat_nxt;
    logic [WW-1:0]     wd_cnt, wd_nxt;
    logic              skip_b, skip_b_nxt;
    logic              b_held, b_held_nxt;
    logic              err_nxt, start_nxt;
    logic [15:0]       tile_nxt;
    logic              c_push, c_pop, fifo_empty, fifo_full;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     fifo_cnt;
    logic [ACC_BITS:0] mem [DEPTH];

    always_comb begin
        state_nxt       = state;
        beat_nxt        = beat_cnt;
        wd_nxt          = wd_cnt;
        skip_b_nxt      = skip_b;
        b_held_nxt      = b_held;
        err_nxt         = err;
        tile_nxt        = tile_cnt;
        start_nxt       = 1'b0;
        cmd_ready       = 1'b0;
        s_ready         = 1'b0;
        arr_a_ld_start  = 1'b0;
        arr_b_ld_start  = 1'b0;
        arr_a_ld_valid  = 1'b0;
        arr_b_ld_valid  = 1'b0;
        arr_a_ld_data   = '0;
        arr_b_ld_data   = '0;
        arr_c_drain_req = 1'b0;
        c_push          = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    skip_b_nxt = cmd_reuse_b & b_held;
                    state_nxt  = S_LDSTART;
                end
            end
            S_LDSTART: begin
                arr_a_ld_start = 1'b1;
                arr_b_ld_start = ~skip_b;
                beat_nxt       = LD_LAST;
                state_nxt      = S_LD_A;
            end
            S_LD_A: begin
                s_ready        = 1'b1;
                arr_a_ld_valid = s_valid;
                arr_a_ld_data  = s_data;
                if (s_valid) begin
                    if (beat_cnt == '0) begin
                        beat_nxt  = LD_LAST;
                        state_nxt = skip_b ? S_WAIT_LD : S_LD_B;
                    end else begin
                        beat_nxt = beat_cnt - BW'(1);
                    end
                end
            end
            S_LD_B: begin
                s_ready        = 1'b1;
                arr_b_ld_valid = s_valid;
                arr_b_ld_data  = s_data;
                if (s_valid) begin
                    if (beat_cnt == '0) begin
                        b_held_nxt = 1'b1;
                        state_nxt  = S_WAIT_LD;
                    end else begin
                        beat_nxt = beat_cnt - BW'(1);
                    end
                end
            end
            S_WAIT_LD: begin
                if (arr_ld_done) begin
                    start_nxt = 1'b1;
                    wd_nxt    = WD_LAST;
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (arr_done) begin
                    state_nxt = S_DRAIN_REQ;
                end else if (wd_cnt == '0) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    wd_nxt = wd_cnt - WW'(1);
                end
            end
            // The array cannot stall its drain, so the whole tile must fit before asking.
            S_DRAIN_REQ: begin
                if (fifo_empty) begin
                    arr_c_drain_req = 1'b1;
                    state_nxt       = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (arr_c_valid) begin
                    if (fifo_full) err_nxt = 1'b1;
                    else           c_push  = 1'b1;
                    if (arr_c_last) begin
                        tile_nxt  = tile_cnt + 16'd1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            wd_cnt    <= '0;
            skip_b    <= 1'b0;
            b_held    <= 1'b0;
            err       <= 1'b0;
            tile_cnt  <= '0;
            arr_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_nxt;
            wd_cnt    <= wd_nxt;
            skip_b    <= skip_b_nxt;
            b_held    <= b_held_nxt;
            err       <= err_nxt;
            tile_cnt  <= tile_nxt;
            arr_start <= start_nxt;
        end
    end

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_FULL);
    assign c_pop      = ~fifo_empty & m_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (c_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            if (c_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            if (c_push && !c_pop)      fifo_cnt <= fifo_cnt + CW'(1);
            else if (!c_push && c_pop) fifo_cnt <= fifo_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (c_push) mem[wr_ptr] <= {arr_c_last, arr_c_data};
    end

    assign m_valid = ~fifo_empty;
    assign m_data  = fifo_empty ? '0 : mem[rd_ptr][ACC_BITS-1:0];
    assign m_last  = ~fifo_empty & mem[rd_ptr][ACC_BITS];
    assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_sa_tile_ctrl.sv
// Scoreboard bench for sa_tile_ctrl: an array stub performs the 8x8 byte matmul on whatever the
// loaders received, and a reference model predicts the result stream from the words sent.
module tb_sa_tile_ctrl;
    localparam int TIMEOUT  = 1023;
    localparam int DONE_LAT = 25;

    typedef logic [31:0] words_t [16];

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_reuse_b = 1'b0;
    logic        s_valid = 1'b0, s_ready;
    logic [31:0] s_data = '0;
    logic        arr_a_ld_start, arr_a_ld_valid, arr_b_ld_start, arr_b_ld_valid;
    logic [31:0] arr_a_ld_data, arr_b_ld_data;
    logic        arr_ld_done, arr_start, arr_done, arr_c_drain_req;
    logic        arr_c_valid, arr_c_last;
    logic [31:0] arr_c_data;
    logic        m_valid, m_ready = 1'b0, m_last;
    logic [31:0] m_data;
    logic        busy, err;
    logic [15:0] tile_cnt;

    sa_tile_ctrl dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reuse_b(cmd_reuse_b),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .arr_a_ld_start(arr_a_ld_start), .arr_a_ld_valid(arr_a_ld_valid), .arr_a_ld_data(arr_a_ld_data),
        .arr_b_ld_start(arr_b_ld_start), .arr_b_ld_valid(arr_b_ld_valid), .arr_b_ld_data(arr_b_ld_data),
        .arr_ld_done(arr_ld_done), .arr_start(arr_start), .arr_done(arr_done),
        .arr_c_drain_req(arr_c_drain_req), .arr_c_valid(arr_c_valid), .arr_c_data(arr_c_data),
        .arr_c_last(arr_c_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .err(err), .tile_cnt(tile_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic [32:0] sb_q[$];
    words_t cur_a, cur_b, held_b;
    bit b_held_m = 0;
    bit hang = 0;
    int s_pct = 100;
    int mr_mode = 0;
    int a_start_cnt, b_start_cnt, a_valid_cnt, b_valid_cnt, s_hs_cnt, ld_mis, drain_cnt;
    time start_time;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] elem(input words_t w, input int idx);
        logic [31:0] t;
        t = w[idx / 4];
        return t[8 * (idx % 4) +: 8];
    endfunction

    function automatic logic [31:0] matmul(input words_t a, input words_t b, input int i, input int j);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 8; k++) s += 32'(elem(a, i * 8 + k)) * 32'(elem(b, k * 8 + j));
        return s;
    endfunction

    // Array stub: captures loader words, reports load done, completes after DONE_LAT, drains 64 words.
    initial begin : stub
        words_t st_a, st_b;
        int a_cnt, b_cnt, done_tmr, didx;
        bit need_b, loading, draining, nd, ndone, nv, nl;
        logic [31:0] ndat;
        a_cnt = 0; b_cnt = 0; done_tmr = -1; didx = 0;
        need_b = 0; loading = 0; draining = 0;
        arr_ld_done = 0; arr_done = 0; arr_c_valid = 0; arr_c_data = '0; arr_c_last = 0;
        forever begin
            @(negedge clk);
            nd = 0; ndone = 0; nv = 0; nl = 0; ndat = '0;
            if (!rstn) begin
                loading = 0; draining = 0; done_tmr = -1;
            end else begin
                if (arr_a_ld_start) begin a_cnt = 0; b_cnt = 0; need_b = arr_b_ld_start; loading = 1; end
                if (arr_a_ld_valid && a_cnt < 16) begin st_a[a_cnt] = arr_a_ld_data; a_cnt++; end
                if (arr_b_ld_valid && b_cnt < 16) begin st_b[b_cnt] = arr_b_ld_data; b_cnt++; end
                if (loading && a_cnt == 16 && (!need_b || b_cnt == 16)) begin nd = 1; loading = 0; end
                if (arr_start && !hang) done_tmr = DONE_LAT;
                else if (done_tmr > 0) done_tmr--;
                if (done_tmr == 0) begin ndone = 1; done_tmr = -1; end
                if (arr_c_drain_req) begin draining = 1; didx = 0; end
                if (draining) begin
                    nv = 1; ndat = matmul(st_a, st_b, didx / 8, didx % 8); nl = (didx == 63);
                    didx++;
                    if (didx == 64) draining = 0;
                end
            end
            @(posedge clk); #1;
            arr_ld_done = nd; arr_done = ndone; arr_c_valid = nv; arr_c_data = ndat; arr_c_last = nl;
        end
    end

    initial begin : mready_drv
        forever begin
            @(posedge clk); #1;
            m_ready = (mr_mode == 0) ? 1'b0 : (mr_mode == 1) ? 1'b1 : 1'($urandom_range(1));
        end
    end

    initial begin : monitor
        logic [32:0] exp;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (arr_a_ld_start) a_start_cnt++;
                if (arr_b_ld_start) b_start_cnt++;
                if (arr_a_ld_valid) a_valid_cnt++;
                if (arr_b_ld_valid) b_valid_cnt++;
                if (s_valid && s_ready) s_hs_cnt++;
                if ((arr_a_ld_valid || arr_b_ld_valid) != (s_valid && s_ready)) ld_mis++;
                if (arr_a_ld_valid && arr_b_ld_valid) ld_mis++;
                if (arr_a_ld_valid && arr_a_ld_data !== s_data) ld_mis++;
                if (arr_b_ld_valid && arr_b_ld_data !== s_data) ld_mis++;
                if (arr_start) start_time = $time;
                if (arr_c_drain_req) begin
                    drain_cnt++;
                    check("drain_req_fifo_empty", 64'(m_valid), 64'd0);
                end
                if (m_valid && m_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL m_word_unexpected: got %0h expected none", {m_last, m_data});
                    end else begin
                        exp = sb_q.pop_front();
                        check("m_word", 64'({m_last, m_data}), 64'(exp));
                    end
                end
            end
        end
    end

    task automatic stream(input logic [31:0] q[$], input int n);
        int i = 0, guard = 0;
        bit abort = 0;
        while (i < n && !abort) begin
            s_valid = ($urandom_range(99) < s_pct);
            s_data  = q[i];
            @(negedge clk);
            if (s_valid && s_ready) i++;
            @(posedge clk); #1;
            guard++;
            if (guard > 5000) abort = 1;
        end
        s_valid = 1'b0;
        s_data  = '0;
        check("stream_complete", 64'(i), 64'(n));
    endtask

    task automatic issue(input bit reuse, input int n_send, input bit expect_out);
        bit skip, got;
        int n;
        logic [31:0] wq[$];
        words_t eff_b;
        skip = reuse && b_held_m;
        if (skip) eff_b = held_b; else eff_b = cur_b;
        if (expect_out)
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    sb_q.push_back({(i == 7 && j == 7), matmul(cur_a, eff_b, i, j)});
        for (int w = 0; w < 16; w++) wq.push_back(cur_a[w]);
        if (!skip) for (int w = 0; w < 16; w++) wq.push_back(cur_b[w]);
        a_start_cnt = 0; b_start_cnt = 0; a_valid_cnt = 0; b_valid_cnt = 0; s_hs_cnt = 0; ld_mis = 0;
        cmd_valid = 1'b1; cmd_reuse_b = reuse; got = 0; n = 0;
        while (!got && n < 4000) begin
            @(negedge clk);
            got = cmd_ready;
            n++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0; cmd_reuse_b = 1'b0;
        check("cmd_accept", 64'(got), 64'd1);
        stream(wq, (n_send < 0) ? wq.size() : n_send);
        if (n_send < 0) begin
            check("a_ld_start_cnt", 64'(a_start_cnt), 64'd1);
            check("b_ld_start_cnt", 64'(b_start_cnt), skip ? 64'd0 : 64'd1);
            check("a_ld_beats", 64'(a_valid_cnt), 64'd16);
            check("b_ld_beats", 64'(b_valid_cnt), skip ? 64'd0 : 64'd16);
            check("s_beats", 64'(s_hs_cnt), skip ? 64'd16 : 64'd32);
            check("ld_mirror", 64'(ld_mis), 64'd0);
            if (!skip) begin held_b = cur_b; b_held_m = 1; end
        end
    endtask

    task automatic wait_quiet(input string name);
        int n = 0;
        while (n < 20000 && (busy || sb_q.size() != 0 || m_valid)) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 64'(n < 20000), 64'd1);
    endtask

    task automatic rand_ab();
        for (int w = 0; w < 16; w++) begin cur_a[w] = $urandom(); cur_b[w] = $urandom(); end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_tile_cnt"}, 64'(tile_cnt), 64'd0);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        check({tag, "_pulses"}, 64'({arr_a_ld_start, arr_b_ld_start, arr_a_ld_valid, arr_b_ld_valid,
                                     arr_start, arr_c_drain_req, m_last}), 64'd0);
        check({tag, "_data"}, 64'({arr_a_ld_data, arr_b_ld_data} | 64'(m_data)), 64'd0);
    endtask

    initial begin : main
        int d0, n;
        time err_time;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        rstn = 1'b1;
        @(posedge clk); #1;
        mr_mode = 1;

        // T1: A=1, B=2 -> 64 words of 16
        for (int w = 0; w < 16; w++) begin cur_a[w] = 32'h01010101; cur_b[w] = 32'h02020202; end
        issue(0, -1, 1);
        wait_quiet("t1_quiet");
        check("t1_tile_cnt", 64'(tile_cnt), 64'd1);
        check("t1_err", 64'(err), 64'd0);

        // T2: reuse held B, A=3 -> 48
        for (int w = 0; w < 16; w++) begin cur_a[w] = 32'h03030303; cur_b[w] = $urandom(); end
        issue(1, -1, 1);
        wait_quiet("t2_quiet");
        check("t2_tile_cnt", 64'(tile_cnt), 64'd2);

        // T3: output stalled across two tiles
        mr_mode = 0;
        d0 = drain_cnt;
        rand_ab();
        issue(0, -1, 1);
        rand_ab();
        issue(0, -1, 1);
        repeat (200) @(posedge clk);
        #1;
        check("t3_one_drain_while_full", 64'(drain_cnt - d0), 64'd1);
        check("t3_fifo_holding", 64'(m_valid), 64'd1);
        check("t3_busy_waiting", 64'(busy), 64'd1);
        mr_mode = 1;
        wait_quiet("t3_quiet");
        check("t3_drains", 64'(drain_cnt - d0), 64'd2);
        check("t3_err", 64'(err), 64'd0);
        check("t3_tile_cnt", 64'(tile_cnt), 64'd4);

        // T4: random gaps and backpressure
        s_pct = 50; mr_mode = 2;
        rand_ab(); issue(0, -1, 1);
        rand_ab(); issue(1, -1, 1);
        rand_ab(); issue(0, -1, 1);
        wait_quiet("t4_quiet");
        check("t4_err", 64'(err), 64'd0);
        check("t4_tile_cnt", 64'(tile_cnt), 64'd7);

        // T5: array never finishes -> watchdog
        s_pct = 100; mr_mode = 1; hang = 1;
        rand_ab();
        issue(0, -1, 0);
        n = 0;
        while (!err && n < 3000) begin @(negedge clk); n++; end
        err_time = $time;
        check("t5_err_set", 64'(err), 64'd1);
        check("t5_timeout_cycles", 64'((err_time - start_time) / 10), 64'(TIMEOUT));
        @(posedge clk); #1;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_cmd_ready", 64'(cmd_ready), 64'd1);
        check("t5_tile_cnt", 64'(tile_cnt), 64'd7);
        hang = 0;
        rand_ab();
        issue(1, -1, 1);
        wait_quiet("t5_after_quiet");
        check("t5_err_sticky", 64'(err), 64'd1);
        check("t5_after_tile_cnt", 64'(tile_cnt), 64'd8);

        // T6: reset during LD_B, then reuse must fall back to a full load
        rand_ab();
        issue(0, 21, 0);
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check_reset_state("t6");
        b_held_m = 0;
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        rand_ab();
        issue(1, -1, 1);
        wait_quiet("t6_quiet");
        check("t6_tile_cnt", 64'(tile_cnt), 64'd1);
        check("t6_err", 64'(err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : global_guard
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "global timeout");
    end

endmodule
